// File: rtl/egress_port.sv
// rtl/egress_port.sv - per-outport egress stage: per-VC FIFOs, per-VC credits, packet-atomic round-robin onto the link
module egress_port #(
    parameter int NUM_VCS = 2,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int FLIT_W = 32 + VC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLIT_W-1:0]  flit_in,
    input  logic               flit_valid,
    output logic [NUM_VCS-1:0] vc_space,
    output logic [FLIT_W-1:0]  link_out,
    output logic               link_valid,
    input  logic               link_ready,
    input  logic [NUM_VCS-1:0] credit_return,
    output logic [NUM_VCS-1:0] packet_sent,
    output logic               overflow_err,
    output logic               credit_err
);
    // Flit layout: {vc, payload[31:0]}; payload[31:28] carries the header format.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = $clog2(CREDITS + 1);

    localparam logic [3:0] FMT_SHORT_READ  = 4'h0;
    localparam logic [3:0] FMT_SHORT_WRITE = 4'h1;
    localparam logic [3:0] FMT_LONG_READ   = 4'h2;
    localparam logic [3:0] FMT_LONG_WRITE  = 4'h3;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [FLIT_W-1:0]   mem_q [NUM_VCS][DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q [NUM_VCS];
    logic [PTR_W-1:0]    rd_ptr_q [NUM_VCS];
    logic [CNT_W-1:0]    count_q [NUM_VCS];
    logic [CR_W-1:0]     credit_q [NUM_VCS];
    logic [VC_W-1:0]     rr_ptr_q, cur_vc_q;
    logic [7:0]          remaining_q;
    logic                hdr_q;
    logic [NUM_VCS-1:0]  packet_sent_q;
    logic                overflow_q, credit_err_q;

    logic [VC_W-1:0]     wr_vc, win_vc, cand;
    logic [VC_W:0]       cand_sum;
    logic                found, handshake, is_tail, drop;
    logic [NUM_VCS-1:0]  fifo_full, eligible, push_vc, pop_vc;
    logic [3:0]          win_fmt;
    logic [6:0]          win_lo;
    logic [7:0]          body_cnt;

    assign wr_vc        = flit_in[FLIT_W-1 -: VC_W];
    assign vc_space     = ~fifo_full;
    assign packet_sent  = packet_sent_q;
    assign overflow_err = overflow_q;
    assign credit_err   = credit_err_q;

    always_comb begin
        fifo_full = '0;
        eligible  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            fifo_full[v] = (count_q[v] == CNT_W'(DEPTH));
            eligible[v]  = (count_q[v] != '0) && (credit_q[v] != '0);
        end
    end

    // Round-robin search starting at rr_ptr_q; wraps for any NUM_VCS.
    always_comb begin
        found    = 1'b0;
        win_vc   = rr_ptr_q;
        cand     = '0;
        cand_sum = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (VC_W+1)'(i);
            if (cand_sum >= (VC_W+1)'(NUM_VCS))
                cand_sum = cand_sum - (VC_W+1)'(NUM_VCS);
            cand = cand_sum[VC_W-1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                win_vc = cand;
            end
        end
    end

    always_comb begin
        win_fmt = mem_q[win_vc][rd_ptr_q[win_vc]][31:28];
        win_lo  = mem_q[win_vc][rd_ptr_q[win_vc]][6:0];
        case (win_fmt)
            FMT_SHORT_READ, FMT_SHORT_WRITE: body_cnt = {4'b0, win_lo[3:0]};
            FMT_LONG_READ, FMT_LONG_WRITE:   body_cnt = {1'b0, win_lo} + 8'd1;
            default:                         body_cnt = {1'b0, win_lo};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)   state_d = SEND;
            SEND:    if (is_tail) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        link_valid = 1'b0;
        link_out   = '0;
        if (state_q == SEND) begin
            link_out   = mem_q[cur_vc_q][rd_ptr_q[cur_vc_q]];
            link_valid = eligible[cur_vc_q];
        end
    end

    // remaining_q counts body flits still owed after the header; the last one is the tail.
    assign handshake = link_valid && link_ready;
    assign is_tail   = handshake && (hdr_q ? (remaining_q == 8'd0) : (remaining_q == 8'd1));

    always_comb begin
        pop_vc  = '0;
        push_vc = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            pop_vc[v]  = handshake && (cur_vc_q == VC_W'(v));
            push_vc[v] = flit_valid && (wr_vc == VC_W'(v)) && (!fifo_full[v] || pop_vc[v]);
        end
    end

    assign drop = flit_valid && fifo_full[wr_vc] && !pop_vc[wr_vc];

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++)
            if (!rst && push_vc[v]) mem_q[v][wr_ptr_q[v]] <= flit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                credit_q[v] <= CR_W'(CREDITS);
            end
            rr_ptr_q      <= '0;
            cur_vc_q      <= '0;
            remaining_q   <= '0;
            hdr_q         <= 1'b0;
            packet_sent_q <= '0;
            overflow_q    <= 1'b0;
            credit_err_q  <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (push_vc[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
                if (pop_vc[v])  rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
                if (push_vc[v] && !pop_vc[v])      count_q[v] <= count_q[v] + 1'b1;
                else if (pop_vc[v] && !push_vc[v]) count_q[v] <= count_q[v] - 1'b1;
                if (credit_return[v] && !pop_vc[v]) begin
                    if (credit_q[v] == CR_W'(CREDITS)) credit_err_q <= 1'b1;
                    else                               credit_q[v] <= credit_q[v] + 1'b1;
                end else if (pop_vc[v] && !credit_return[v]) begin
                    credit_q[v] <= credit_q[v] - 1'b1;
                end
            end
            if (drop) overflow_q <= 1'b1;
            if (state_q == IDLE && found) begin
                cur_vc_q    <= win_vc;
                remaining_q <= body_cnt;
                hdr_q       <= 1'b1;
            end
            if (handshake) begin
                hdr_q <= 1'b0;
                if (!hdr_q) remaining_q <= remaining_q - 8'd1;
            end
            packet_sent_q <= '0;
            if (is_tail) begin
                packet_sent_q[cur_vc_q] <= 1'b1;
                rr_ptr_q <= (cur_vc_q == VC_W'(NUM_VCS - 1)) ? '0 : cur_vc_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_egress_port.sv
// tb/tb_egress_port.sv - directed self-checking bench for egress_port
module tb_egress_port;
    localparam logic [3:0] SR = 4'h0, SW = 4'h1, LR = 4'h2, LW = 4'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] flit_in;
    logic        flit_valid;
    logic [1:0]  vc_space;
    logic [32:0] link_out;
    logic        link_valid, link_ready;
    logic [1:0]  credit_return, packet_sent;
    logic        overflow_err, credit_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [32:0] sent_q[$];
    int          sent_cyc[$];
    int          ps_cnt[2];
    int          ps_cyc[2];

    egress_port #(.NUM_VCS(2), .DEPTH(4), .CREDITS(4)) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
        .vc_space(vc_space), .link_out(link_out), .link_valid(link_valid),
        .link_ready(link_ready), .credit_return(credit_return),
        .packet_sent(packet_sent), .overflow_err(overflow_err), .credit_err(credit_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (link_valid && link_ready) begin
                sent_q.push_back(link_out);
                sent_cyc.push_back(cyc);
            end
            for (int v = 0; v < 2; v++)
                if (packet_sent[v]) begin
                    ps_cnt[v]++;
                    ps_cyc[v] = cyc;
                end
        end
    end

    function automatic logic [32:0] mk(input logic vc, input logic [3:0] fmt, input logic [27:0] lo);
        return {vc, fmt, lo};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [32:0] f);
        flit_valid = 1'b1;
        flit_in    = f;
        tick();
        flit_valid = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget);
        for (int i = 0; i < budget && sent_q.size() < n; i++) tick();
    endtask

    task automatic do_reset;
        rst = 1'b1; flit_valid = 1'b0; flit_in = '0; link_ready = 1'b0; credit_return = '0;
        tick(); tick();
        rst = 1'b0;
        sent_q.delete(); sent_cyc.delete();
        ps_cnt[0] = 0; ps_cnt[1] = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL reset_link_valid: got %b expected 0", link_valid); end
        checks++; if (link_out !== 33'h0) begin errors++; $display("FAIL reset_link_out: got %h expected 0", link_out); end
        checks++; if (packet_sent !== 2'b00) begin errors++; $display("FAIL reset_packet_sent: got %b expected 00", packet_sent); end
        checks++; if ({overflow_err, credit_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {overflow_err, credit_err}); end
        checks++; if (vc_space !== 2'b11) begin errors++; $display("FAIL reset_vc_space: got %b expected 11", vc_space); end
    endtask

    task automatic test_short_write;
        logic [32:0] h, b1, b2, h2;
        h = mk(0, SW, 28'h2); b1 = mk(0, 4'hB, 28'h1); b2 = mk(0, 4'hB, 28'h2); h2 = mk(0, SW, 28'h1);
        do_reset();
        link_ready = 1'b1;
        push(h);
        checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL short_t1_valid: got %b expected 0", link_valid); end
        push(b1);
        checks++; if (link_valid !== 1'b1 || link_out !== h) begin errors++; $display("FAIL short_t2_head: got %b/%h expected 1/%h", link_valid, link_out, h); end
        push(b2);
        wait_sent(3, 10); tick(); tick();
        checks++; if (sent_q.size() != 3) begin errors++; $display("FAIL short_count: got %0d expected 3", sent_q.size()); end
        else begin
            checks++; if (sent_q[0] !== h || sent_q[1] !== b1 || sent_q[2] !== b2) begin errors++; $display("FAIL short_order: got %h %h %h expected %h %h %h", sent_q[0], sent_q[1], sent_q[2], h, b1, b2); end
            checks++; if (sent_cyc[2] - sent_cyc[0] != 2) begin errors++; $display("FAIL short_stream: got span %0d expected 2", sent_cyc[2] - sent_cyc[0]); end
            checks++; if (ps_cnt[0] != 1 || ps_cyc[0] != sent_cyc[2] + 1) begin errors++; $display("FAIL short_psent: got cnt %0d cyc %0d expected 1 %0d", ps_cnt[0], ps_cyc[0], sent_cyc[2] + 1); end
        end
        checks++; if (ps_cnt[1] != 0) begin errors++; $display("FAIL short_psent_vc1: got %0d expected 0", ps_cnt[1]); end
        push(h2); push(b1);
        repeat (8) tick();
        checks++; if (sent_q.size() != 4 || link_valid !== 1'b0) begin errors++; $display("FAIL short_credit_left: got %0d sent valid %b expected 4 sent valid 0", sent_q.size(), link_valid); end
    endtask

    task automatic test_credit_stall;
        logic [32:0] exp_q[$];
        int bad;
        do_reset();
        link_ready = 1'b1;
        exp_q.push_back(mk(1, LW, 28'h5));
        for (int i = 1; i <= 6; i++) exp_q.push_back(mk(1, 4'hC, 28'(i)));
        foreach (exp_q[i]) push(exp_q[i]);
        repeat (6) tick();
        checks++; if (sent_q.size() != 4 || link_valid !== 1'b0 || ps_cnt[1] != 0) begin errors++; $display("FAIL credit_stall: got %0d sent valid %b psent %0d expected 4 0 0", sent_q.size(), link_valid, ps_cnt[1]); end
        for (int i = 0; i < 3; i++) begin
            credit_return = 2'b10; tick(); credit_return = 2'b00; tick();
        end
        wait_sent(7, 20); tick(); tick();
        bad = 0;
        if (sent_q.size() == 7) foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) bad++;
        checks++; if (sent_q.size() != 7 || bad != 0) begin errors++; $display("FAIL credit_resume: got %0d sent %0d wrong expected 7 sent 0 wrong", sent_q.size(), bad); end
        checks++; if (ps_cnt[1] != 1) begin errors++; $display("FAIL credit_psent: got %0d expected 1", ps_cnt[1]); end
    endtask

    task automatic test_back_to_back;
        logic [32:0] a0, a1, b0, b1, c0;
        logic [32:0] exp_q[$];
        int bad;
        a0 = mk(0, SW, 28'h1); a1 = mk(0, 4'hA, 28'h1); b0 = mk(1, SW, 28'h1); b1 = mk(1, 4'hB, 28'h1); c0 = mk(0, SR, 28'h0);
        do_reset();
        push(a0); push(b0); push(a1); push(b1); push(c0);
        link_ready = 1'b1;
        wait_sent(5, 30); tick(); tick();
        exp_q = '{a0, a1, b0, b1, c0};
        bad = 0;
        if (sent_q.size() == 5) foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) bad++;
        checks++; if (sent_q.size() != 5 || bad != 0) begin errors++; $display("FAIL rr_order: got %0d sent %0d out of order expected 5 sent 0", sent_q.size(), bad); end
        checks++; if (ps_cnt[0] != 2 || ps_cnt[1] != 1) begin errors++; $display("FAIL rr_psent: got %0d/%0d expected 2/1", ps_cnt[0], ps_cnt[1]); end
    endtask

    task automatic test_ready_stall;
        logic [32:0] h, d1, d2, d3, saved;
        h = mk(0, SW, 28'h3); d1 = mk(0, 4'hD, 28'h1); d2 = mk(0, 4'hD, 28'h2); d3 = mk(0, 4'hD, 28'h3);
        do_reset();
        link_ready = 1'b1;
        push(h); push(d1); push(d2); push(d3);
        wait_sent(2, 10);
        link_ready = 1'b0;
        saved = link_out;
        checks++; if (saved !== d2) begin errors++; $display("FAIL stall_head: got %h expected %h", saved, d2); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (link_out !== saved || link_valid !== 1'b1 || sent_q.size() != 2) begin errors++; $display("FAIL stall_hold: got %h/%b/%0d expected %h/1/2", link_out, link_valid, sent_q.size(), saved); end
        end
        link_ready = 1'b1;
        wait_sent(4, 10); tick(); tick();
        checks++; if (sent_q.size() != 4 || sent_q[sent_q.size()-1] !== d3 || ps_cnt[0] != 1) begin errors++; $display("FAIL stall_finish: got %0d sent psent %0d expected 4 sent ending %h psent 1", sent_q.size(), ps_cnt[0], d3); end
        push(mk(0, SR, 28'h0));
        repeat (5) tick();
        checks++; if (sent_q.size() != 4 || link_valid !== 1'b0) begin errors++; $display("FAIL stall_credit: got %0d sent valid %b expected 4 0", sent_q.size(), link_valid); end
    endtask

    task automatic test_overflow;
        logic [32:0] f[5];
        f[0] = mk(0, SW, 28'h3);
        for (int i = 1; i < 4; i++) f[i] = mk(0, 4'h7, 28'(i));
        f[4] = mk(0, 4'hE, 28'h4);
        do_reset();
        for (int i = 0; i < 4; i++) push(f[i]);
        checks++; if (vc_space !== 2'b10 || overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_full: got %b/%b expected 10/0", vc_space, overflow_err); end
        push(f[4]);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
        link_ready = 1'b1;
        wait_sent(4, 10); repeat (4) tick();
        checks++; if (sent_q.size() != 4 || sent_q[sent_q.size()-1] !== f[3]) begin errors++; $display("FAIL ovf_drop: got %0d sent expected 4 ending %h", sent_q.size(), f[3]); end
        checks++; if (overflow_err !== 1'b1 || vc_space !== 2'b11) begin errors++; $display("FAIL ovf_sticky: got %b/%b expected 1/11", overflow_err, vc_space); end
    endtask

    task automatic test_credit_edge_and_reset;
        do_reset();
        link_ready = 1'b1;
        push(mk(0, SW, 28'h4)); push(mk(0, 4'h5, 28'h1));
        credit_return = 2'b01;
        push(mk(0, 4'h5, 28'h2));
        credit_return = 2'b00;
        push(mk(0, 4'h5, 28'h3)); push(mk(0, 4'h5, 28'h4));
        wait_sent(5, 15); tick(); tick();
        checks++; if (sent_q.size() != 5 || credit_err !== 1'b0 || ps_cnt[0] != 1) begin errors++; $display("FAIL same_cycle_credit: got %0d sent err %b psent %0d expected 5 0 1", sent_q.size(), credit_err, ps_cnt[0]); end
        credit_return = 2'b10; tick(); credit_return = 2'b00; tick();
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL credit_err: got %b expected 1", credit_err); end
        push(mk(1, SW, 28'h3)); push(mk(1, 4'h6, 28'h1)); push(mk(1, 4'h6, 28'h2));
        rst = 1'b1;
        tick();
        checks++; if (link_valid !== 1'b0 || link_out !== 33'h0 || packet_sent !== 2'b00) begin errors++; $display("FAIL midrst_link: got %b/%h/%b expected 0/0/00", link_valid, link_out, packet_sent); end
        checks++; if (credit_err !== 1'b0 || overflow_err !== 1'b0 || vc_space !== 2'b11) begin errors++; $display("FAIL midrst_state: got %b/%b/%b expected 0/0/11", credit_err, overflow_err, vc_space); end
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %b expected 0", link_valid); end
    endtask

    initial begin
        test_reset();
        test_short_write();
        test_credit_stall();
        test_back_to_back();
        test_ready_stall();
        test_overflow();
        test_credit_edge_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
